// File: rtl/rpc_cmd_arbiter.sv
// Command arbiter between the refresh timer, the ZQ-cal timer and the
// direct-command FIFO. It feeds CMD_FSM through a single registered slot.
// Priority is ref > zqc > direct. A starvation guard forces a direct grant
// after STARVE_LIMIT consecutive maintenance grants while direct waits.
// Maintenance requests are held off until DRAM init has completed.
module rpc_cmd_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CMD_WIDTH    = 19
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rpc_init_completed_i,
    input  logic                 ref_valid_i,
    output logic                 ref_ready_o,
    input  logic [CMD_WIDTH-1:0] ref_cmd_i,
    input  logic                 zqc_valid_i,
    output logic                 zqc_ready_o,
    input  logic [CMD_WIDTH-1:0] zqc_cmd_i,
    input  logic                 direct_cmd_valid_i,
    output logic                 direct_cmd_ready_o,
    input  logic [CMD_WIDTH-1:0] direct_cmd_i,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic [CMD_WIDTH-1:0] cmd_o,
    output logic [1:0]           cmd_src_o,
    output logic                 idle_o
);

    localparam int STARVE_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] SRC_NONE   = 2'b00;
    localparam logic [1:0] SRC_REF    = 2'b01;
    localparam logic [1:0] SRC_ZQC    = 2'b10;
    localparam logic [1:0] SRC_DIRECT = 2'b11;

    logic                    cmd_valid_q, cmd_valid_d;
    logic [CMD_WIDTH-1:0]    cmd_q, cmd_d;
    logic [1:0]              cmd_src_q, cmd_src_d;
    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic load_en;
    logic grant_ref, grant_zqc, grant_direct;

    // Grant selection: starved direct first, then fixed priority among eligible sources.
    always_comb begin
        grant_ref    = 1'b0;
        grant_zqc    = 1'b0;
        grant_direct = 1'b0;
        if (direct_cmd_valid_i && (starve_cnt_q == STARVE_MAX)) begin
            grant_direct = 1'b1;
        end else if (ref_valid_i && rpc_init_completed_i) begin
            grant_ref = 1'b1;
        end else if (zqc_valid_i && rpc_init_completed_i) begin
            grant_zqc = 1'b1;
        end else if (direct_cmd_valid_i) begin
            grant_direct = 1'b1;
        end
    end

    // Handshake: ready only when the slot can take a command; forced low in reset
    // so nothing is accepted on a reset cycle.
    always_comb begin
        load_en            = !cmd_valid_q || cmd_ready_i;
        ref_ready_o        = rst_ni && load_en && grant_ref;
        zqc_ready_o        = rst_ni && load_en && grant_zqc;
        direct_cmd_ready_o = rst_ni && load_en && grant_direct;
    end

    // Next-state for the output slot and the starvation counter.
    always_comb begin
        cmd_valid_d  = cmd_valid_q;
        cmd_d        = cmd_q;
        cmd_src_d    = cmd_src_q;
        starve_cnt_d = starve_cnt_q;
        if (load_en) begin
            cmd_valid_d = grant_ref || grant_zqc || grant_direct;
            if (grant_ref) begin
                cmd_d     = ref_cmd_i;
                cmd_src_d = SRC_REF;
            end else if (grant_zqc) begin
                cmd_d     = zqc_cmd_i;
                cmd_src_d = SRC_ZQC;
            end else if (grant_direct) begin
                cmd_d     = direct_cmd_i;
                cmd_src_d = SRC_DIRECT;
            end else begin
                // Slot empties; cmd_o deliberately keeps its last value.
                cmd_src_d = SRC_NONE;
            end

            if (grant_direct || !direct_cmd_valid_i) begin
                starve_cnt_d = '0;
            end else if ((grant_ref || grant_zqc) && (starve_cnt_q != STARVE_MAX)) begin
                starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
            end
        end
    end

    // State registers; reset discards any held command.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_valid_q  <= 1'b0;
            cmd_q        <= '0;
            cmd_src_q    <= SRC_NONE;
            starve_cnt_q <= '0;
        end else begin
            cmd_valid_q  <= cmd_valid_d;
            cmd_q        <= cmd_d;
            cmd_src_q    <= cmd_src_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Output drive.
    always_comb begin
        cmd_valid_o = cmd_valid_q;
        cmd_o       = cmd_q;
        cmd_src_o   = cmd_src_q;
        idle_o      = !cmd_valid_q && !ref_valid_i && !zqc_valid_i && !direct_cmd_valid_i;
    end

endmodule
